pulse_burst_gen: RTL and testbench



---
 rtl/pulse_burst_gen.sv | 156 +++++++++++++++
 tb/tb_pulse_burst_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_gen.sv
// Pulse-train transmitter: emits N pulses of programmable high time and period.
// Latency: first rising edge of pulse_out one cycle after burst_start is sampled.
// No backpressure: starts while busy are dropped; abort returns to IDLE next cycle.
module pulse_burst_gen #(
    parameter int CNT_WIDTH  = 16,
    parameter int TIME_WIDTH = 16
) (
    input  logic                  pulse_clock,
    input  logic                  pulse_reset_n,
    input  logic                  burst_start,
    input  logic                  burst_abort,
    input  logic [CNT_WIDTH-1:0]  burst_count,
    input  logic [TIME_WIDTH-1:0] burst_high,
    input  logic [TIME_WIDTH-1:0] burst_period,
    output logic                  pulse_out,
    output logic                  burst_busy,
    output logic                  burst_done,
    output logic [CNT_WIDTH-1:0]  pulses_sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  count_lat;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [TIME_WIDTH-1:0] high_lat;
    logic [TIME_WIDTH-1:0] high_nxt;
    logic [TIME_WIDTH-1:0] low_lat;
    logic [TIME_WIDTH-1:0] low_nxt;
    logic [TIME_WIDTH-1:0] phase;
    logic [TIME_WIDTH-1:0] phase_nxt;
    logic                  pulse_nxt;
    logic                  busy_nxt;
    logic                  done_nxt;
    logic [CNT_WIDTH-1:0]  sent_nxt;
    logic [TIME_WIDTH-1:0] high_eff;
    logic [TIME_WIDTH-1:0] low_eff;

    // Low time is max(period - high, 1): equivalent to max(period, high+1) - high,
    // but never forms high+1, so an all-ones high time cannot overflow.
    always_comb begin
        high_eff = (burst_high == '0) ? TIME_WIDTH'(1) : burst_high;
        low_eff  = (burst_period > high_eff) ? (burst_period - high_eff) : TIME_WIDTH'(1);
    end

    always_ff @(posedge pulse_clock or negedge pulse_reset_n) begin
        if (!pulse_reset_n) begin
            state       <= IDLE;
            count_lat   <= '0;
            high_lat    <= '0;
            low_lat     <= '0;
            phase       <= '0;
            pulse_out   <= 1'b0;
            burst_busy  <= 1'b0;
            burst_done  <= 1'b0;
            pulses_sent <= '0;
        end else begin
            state       <= state_nxt;
            count_lat   <= count_nxt;
            high_lat    <= high_nxt;
            low_lat     <= low_nxt;
            phase       <= phase_nxt;
            pulse_out   <= pulse_nxt;
            burst_busy  <= busy_nxt;
            burst_done  <= done_nxt;
            pulses_sent <= sent_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count_lat;
        high_nxt  = high_lat;
        low_nxt   = low_lat;
        phase_nxt = phase;
        pulse_nxt = pulse_out;
        busy_nxt  = burst_busy;
        done_nxt  = burst_done;
        sent_nxt  = pulses_sent;

        case (state)
            IDLE, DONE: begin
                // Start outranks a simultaneous abort here: abort only acts while busy.
                if (burst_start) begin
                    count_nxt = burst_count;
                    high_nxt  = high_eff;
                    low_nxt   = low_eff;
                    phase_nxt = TIME_WIDTH'(1);
                    sent_nxt  = '0;
                    done_nxt  = 1'b0;
                    if (burst_count == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        pulse_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = HIGH;
                        pulse_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        sent_nxt  = CNT_WIDTH'(1);
                    end
                end
            end

            HIGH: begin
                if (burst_abort) begin
                    state_nxt = IDLE;
                    pulse_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (phase == high_lat) begin
                    state_nxt = LOW;
                    pulse_nxt = 1'b0;
                    phase_nxt = TIME_WIDTH'(1);
                end else begin
                    phase_nxt = phase + TIME_WIDTH'(1);
                end
            end

            LOW: begin
                if (burst_abort) begin
                    state_nxt = IDLE;
                    pulse_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b0;
                end else if (phase == low_lat) begin
                    phase_nxt = TIME_WIDTH'(1);
                    if (pulses_sent < count_lat) begin
                        state_nxt = HIGH;
                        pulse_nxt = 1'b1;
                        sent_nxt  = pulses_sent + CNT_WIDTH'(1);
                    end else begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    phase_nxt = phase + TIME_WIDTH'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                pulse_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Scoreboard bench for pulse_burst_gen: stimulus queues expected edge events,
// a negedge monitor matches observed edges of pulse_out / burst_done against them.
module tb_pulse_burst_gen;

    localparam int CW = 16;
    localparam int TW = 16;
    localparam int K_RISE  = 0;
    localparam int K_FALL  = 1;
    localparam int K_DRISE = 2;
    localparam int K_DFALL = 3;

    logic          pulse_clock = 1'b0;
    logic          pulse_reset_n = 1'b0;
    logic          burst_start = 1'b0;
    logic          burst_abort = 1'b0;
    logic [CW-1:0] burst_count = '0;
    logic [TW-1:0] burst_high = '0;
    logic [TW-1:0] burst_period = '0;
    logic          pulse_out;
    logic          burst_busy;
    logic          burst_done;
    logic [CW-1:0] pulses_sent;

    pulse_burst_gen #(.CNT_WIDTH(CW), .TIME_WIDTH(TW)) dut (
        .pulse_clock   (pulse_clock),
        .pulse_reset_n (pulse_reset_n),
        .burst_start   (burst_start),
        .burst_abort   (burst_abort),
        .burst_count   (burst_count),
        .burst_high    (burst_high),
        .burst_period  (burst_period),
        .pulse_out     (pulse_out),
        .burst_busy    (burst_busy),
        .burst_done    (burst_done),
        .pulses_sent   (pulses_sent)
    );

    always #5 pulse_clock = ~pulse_clock;

    typedef struct {
        int kind;
        int cyc;
        int ps;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_done_cyc = -1;
    bit   done_hi = 1'b0;
    logic prev_pulse = 1'b0;
    logic prev_done = 1'b0;

    always @(posedge pulse_clock) cyc <= cyc + 1;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int kind, int c, int ps);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.ps   = ps;
        exp_q.push_back(e);
    endfunction

    function automatic void match(int kind, int ps);
        int idx = -1;
        foreach (exp_q[i]) begin
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc) idx = i;
        end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d ps %0d expected no event", kind, cyc, ps);
        end else begin
            chk($sformatf("event_ps_kind%0d_cyc%0d", kind, cyc), ps, exp_q[idx].ps);
            exp_q.delete(idx);
        end
    endfunction

    always @(negedge pulse_clock) begin
        if (pulse_out && !prev_pulse) match(K_RISE, int'(pulses_sent));
        if (!pulse_out && prev_pulse) match(K_FALL, int'(pulses_sent));
        if (burst_done && !prev_done) begin
            match(K_DRISE, int'(pulses_sent));
            last_done_cyc = cyc;
        end
        if (!burst_done && prev_done) match(K_DFALL, int'(pulses_sent));
        prev_pulse = pulse_out;
        prev_done  = burst_done;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge pulse_clock);
    endtask

    // Issues a one-cycle start and queues the first nfull complete pulses
    // (plus the done edge when with_done) from hand-supplied effective timing.
    task automatic run_burst(input int n, input int hraw, input int praw,
                             input int heff, input int peff, input int nfull,
                             input bit with_done, input bit with_abort, output int s);
        burst_count  = CW'(n);
        burst_high   = TW'(hraw);
        burst_period = TW'(praw);
        burst_start  = 1'b1;
        burst_abort  = with_abort;
        s = cyc + 1;
        if (done_hi) push(K_DFALL, s, (n > 0) ? 1 : 0);
        for (int k = 0; k < nfull; k++) begin
            push(K_RISE, s + k * peff, k + 1);
            push(K_FALL, s + k * peff + heff, k + 1);
        end
        if (with_done) push(K_DRISE, s + n * peff, n);
        @(negedge pulse_clock);
        burst_start = 1'b0;
        burst_abort = 1'b0;
    endtask

    task automatic check_drained(input string name);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int s;

        // Reset state while reset is held
        repeat (3) @(negedge pulse_clock);
        chk("reset_pulse_out", pulse_out, 0);
        chk("reset_busy", burst_busy, 0);
        chk("reset_done", burst_done, 0);
        chk("reset_pulses_sent", pulses_sent, 0);
        pulse_reset_n = 1'b1;
        repeat (2) @(negedge pulse_clock);

        // Basic burst: 15 pulses, 1 high / 1 low
        run_burst(15, 1, 2, 1, 2, 15, 1'b1, 1'b0, s);
        chk("basic_busy_first", burst_busy, 1);
        wait_until(s + 32);
        chk("basic_done_latency", last_done_cyc - s, 30);
        chk("basic_pulses_sent", pulses_sent, 15);
        chk("basic_busy_end", burst_busy, 0);
        check_drained("basic_drained");
        done_hi = 1'b1;

        // Clamping: high=0, period=0 behaves as 1/2
        run_burst(3, 0, 0, 1, 2, 3, 1'b1, 1'b0, s);
        wait_until(s + 8);
        chk("clampA_done_latency", last_done_cyc - s, 6);
        check_drained("clampA_drained");

        // Clamping: period below high -> 5 high / 1 low
        run_burst(2, 5, 3, 5, 6, 2, 1'b1, 1'b0, s);
        wait_until(s + 14);
        chk("clampB_done_latency", last_done_cyc - s, 12);
        chk("clampB_pulses_sent", pulses_sent, 2);
        check_drained("clampB_drained");

        // Abort in the HIGH phase of pulse 4; a start mid-burst is ignored
        run_burst(10, 2, 4, 2, 4, 3, 1'b0, 1'b0, s);
        push(K_RISE, s + 12, 4);
        push(K_FALL, s + 13, 4);
        wait_until(s + 5);
        burst_start = 1'b1;
        burst_count = CW'(1);
        burst_high  = TW'(7);
        @(negedge pulse_clock);
        burst_start = 1'b0;
        wait_until(s + 12);
        burst_abort = 1'b1;
        @(negedge pulse_clock);
        burst_abort = 1'b0;
        chk("abort_pulse_out", pulse_out, 0);
        chk("abort_busy", burst_busy, 0);
        chk("abort_done", burst_done, 0);
        chk("abort_pulses_sent", pulses_sent, 4);
        wait_until(s + 24);
        chk("abort_hold_pulses_sent", pulses_sent, 4);
        check_drained("abort_drained");
        done_hi = 1'b0;

        // Zero count from IDLE, with abort also high: start wins
        run_burst(0, 3, 5, 3, 5, 0, 1'b1, 1'b1, s);
        wait_until(s + 4);
        chk("zero_done", burst_done, 1);
        chk("zero_pulses_sent", pulses_sent, 0);
        chk("zero_done_latency", last_done_cyc - s, 0);
        check_drained("zero_drained");
        done_hi = 1'b1;

        // Asynchronous reset mid-burst (pulse 13 high at the time)
        run_burst(100, 3, 4, 3, 4, 12, 1'b0, 1'b0, s);
        push(K_RISE, s + 48, 13);
        push(K_FALL, s + 50, 0);
        wait_until(s + 49);
        #2 pulse_reset_n = 1'b0;
        #1;
        chk("rst_mid_pulse_out", pulse_out, 0);
        chk("rst_mid_busy", burst_busy, 0);
        chk("rst_mid_done", burst_done, 0);
        chk("rst_mid_pulses_sent", pulses_sent, 0);
        wait_until(s + 51);
        pulse_reset_n = 1'b1;
        repeat (2) @(negedge pulse_clock);
        check_drained("rst_mid_drained");
        done_hi = 1'b0;

        run_burst(5, 1, 3, 1, 3, 5, 1'b1, 1'b0, s);
        wait_until(s + 17);
        chk("post_rst_done_latency", last_done_cyc - s, 15);
        chk("post_rst_pulses_sent", pulses_sent, 5);
        check_drained("post_rst_drained");
        done_hi = 1'b1;

        // Re-arm: start held high, three bursts of 2 pulses, 5-cycle cadence
        burst_count  = CW'(2);
        burst_high   = TW'(1);
        burst_period = TW'(2);
        burst_start  = 1'b1;
        s = cyc + 1;
        push(K_DFALL, s, 1);
        for (int j = 0; j < 3; j++) begin
            push(K_RISE,  s + 5 * j,     1);
            push(K_FALL,  s + 5 * j + 1, 1);
            push(K_RISE,  s + 5 * j + 2, 2);
            push(K_FALL,  s + 5 * j + 3, 2);
            push(K_DRISE, s + 5 * j + 4, 2);
            if (j < 2) push(K_DFALL, s + 5 * j + 5, 1);
        end
        wait_until(s + 14);
        burst_start = 1'b0;
        wait_until(s + 20);
        chk("rearm_done_hold", burst_done, 1);
        chk("rearm_pulses_sent", pulses_sent, 2);
        chk("rearm_last_done", last_done_cyc - s, 14);
        check_drained("rearm_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
